// File: rtl/ram8.sv
`timescale 1ns/1ns
`default_nettype none
// ============================================================================
// ram8 : eight-word register file with per-word written-since-reset flags.
// Define RAM8_READ_REG_EN for a registered (read-first, 1-cycle) read port.
// Rev 1.0 - initial release
// ============================================================================
module ram8 #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  input  logic             LOAD,
  input  logic [2:0]       ADDRESS,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID
);

  localparam int c_WORDS = 8;

  logic [c_WORDS-1:0]            w_load_en;
  logic [c_WORDS-1:0][WIDTH-1:0] mem_q;
  logic [c_WORDS-1:0][WIDTH-1:0] mem_d;
  logic [c_WORDS-1:0]            valid_q;
  logic [c_WORDS-1:0]            valid_d;
  logic [WIDTH-1:0]              w_rd_data;
  logic                          w_rd_valid;

  // 1-to-8 load demultiplexer: at most one word enable is active.
  generate
    for (genvar i = 0; i < c_WORDS; i++) begin : g_demux
      assign w_load_en[i] = LOAD && (ADDRESS == 3'(i));
    end
  endgenerate

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    for (int i = 0; i < c_WORDS; i++) begin
      if (w_load_en[i]) begin
        mem_d[i]   = IN;
        valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_q   <= '0;
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  assign w_rd_data  = mem_q[ADDRESS];
  assign w_rd_valid = valid_q[ADDRESS];

`ifdef RAM8_READ_REG_EN
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  // Samples pre-write storage, so a same-address write reads first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= w_rd_data;
      rd_valid_q <= w_rd_valid;
    end
  end

  assign OUT       = rd_data_q;
  assign OUT_VALID = rd_valid_q;
`else
  assign OUT       = w_rd_data;
  assign OUT_VALID = w_rd_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram8.sv
`timescale 1ns/1ns
`default_nettype none
// ============================================================================
// tb_ram8 : scoreboard bench for ram8 (either read-port build).
// Rev 1.0 - initial release
// ============================================================================
module tb_ram8;

  localparam int c_W = 16;

  logic           CLK;
  logic           RST;
  logic [c_W-1:0] IN;
  logic           LOAD;
  logic [2:0]     ADDRESS;
  logic [c_W-1:0] OUT;
  logic           OUT_VALID;

  int n_pass;
  int n_total;

  logic [c_W-1:0] model_mem [8];
  logic           model_v   [8];
  logic [c_W:0]   sb [$];
  logic [c_W:0]   exp_v;

  ram8 #(.WIDTH(c_W)) u_dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN       (IN),
    .LOAD     (LOAD),
    .ADDRESS  (ADDRESS),
    .OUT      (OUT),
    .OUT_VALID(OUT_VALID)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  always @(posedge CLK) begin
    if (LOAD === 1'b1 && $isunknown(ADDRESS)) begin
      n_total++;
      $display("FAIL addr_unknown: ADDRESS=%b while LOAD=1, required a known address", ADDRESS);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = '0;
      model_v[i]   = 1'b0;
    end
  endtask

  task automatic write(input logic [2:0] a, input logic [c_W-1:0] d);
    @(negedge CLK);
    ADDRESS = a;
    IN      = d;
    LOAD    = 1'b1;
    @(posedge CLK);
    #1;
    LOAD         = 1'b0;
    model_mem[a] = d;
    model_v[a]   = 1'b1;
  endtask

  // Presents a read address and waits until its data is observable.
  task automatic rd_wait(input logic [2:0] a);
    @(negedge CLK);
    LOAD    = 1'b0;
    ADDRESS = a;
`ifdef RAM8_READ_REG_EN
    @(posedge CLK);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    RST = 1'b1; LOAD = 1'b0; IN = '0; ADDRESS = '0;
    #25;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 8; i++) write(3'(i), 16'hFFFF);
    @(negedge CLK);
    RST = 1'b1;
    model_clear();
    #1;
    for (int j = 0; j < 8; j++) begin
      sb.push_back({model_mem[j], model_v[j]});
      ADDRESS = 3'(j);
      #1;
      exp_v = sb.pop_front();
      n_total++;
      if ({OUT, OUT_VALID} !== exp_v)
        $display("FAIL reset_addr%0d: OUT=%h VALID=%b, required OUT=%h VALID=%b",
                 j, OUT, OUT_VALID, exp_v[c_W:1], exp_v[0]);
      else n_pass++;
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_walk();
    for (int k = 0; k < 8; k++) begin
      write(3'(k), 16'(16'h0011 * (k + 1)));
      for (int j = 0; j < 8; j++) begin
        sb.push_back({model_mem[j], model_v[j]});
        rd_wait(3'(j));
        exp_v = sb.pop_front();
        n_total++;
        if ({OUT, OUT_VALID} !== exp_v)
          $display("FAIL walk_k%0d_addr%0d: OUT=%h VALID=%b, required OUT=%h VALID=%b",
                   k, j, OUT, OUT_VALID, exp_v[c_W:1], exp_v[0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hold();
    IN = 16'hDEAD;
    for (int c = 0; c < 4; c++) begin
      sb.push_back({16'h0044, 1'b1});
      rd_wait(3'd3);
      exp_v = sb.pop_front();
      n_total++;
      if ({OUT, OUT_VALID} !== exp_v)
        $display("FAIL hold_cycle%0d: OUT=%h VALID=%b, required OUT=%h VALID=%b",
                 c, OUT, OUT_VALID, exp_v[c_W:1], exp_v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_read_during_write();
    sb.push_back({16'h0066, 1'b1});
    sb.push_back({16'hBEEF, 1'b1});
    @(negedge CLK);
    ADDRESS = 3'd5;
    IN      = 16'hBEEF;
    LOAD    = 1'b1;
`ifdef RAM8_READ_REG_EN
    @(posedge CLK);
    #1;
    LOAD = 1'b0;
`else
    #1;
`endif
    exp_v = sb.pop_front();
    n_total++;
    if ({OUT, OUT_VALID} !== exp_v)
      $display("FAIL rdw_old: OUT=%h VALID=%b, required OUT=%h VALID=%b",
               OUT, OUT_VALID, exp_v[c_W:1], exp_v[0]);
    else n_pass++;
    @(posedge CLK);
    #1;
    LOAD = 1'b0;
    model_mem[5] = 16'hBEEF;
    exp_v = sb.pop_front();
    n_total++;
    if ({OUT, OUT_VALID} !== exp_v)
      $display("FAIL rdw_new: OUT=%h VALID=%b, required OUT=%h VALID=%b",
               OUT, OUT_VALID, exp_v[c_W:1], exp_v[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    @(negedge CLK);
    ADDRESS = 3'd2;
    IN      = 16'h1234;
    LOAD    = 1'b1;
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST  = 1'b0;
    LOAD = 1'b0;
    model_clear();
    for (int j = 0; j < 8; j++) begin
      sb.push_back({model_mem[j], model_v[j]});
      rd_wait(3'(j));
      exp_v = sb.pop_front();
      n_total++;
      if ({OUT, OUT_VALID} !== exp_v)
        $display("FAIL rst_mid_write_addr%0d: OUT=%h VALID=%b, required OUT=%h VALID=%b",
                 j, OUT, OUT_VALID, exp_v[c_W:1], exp_v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_valid_tracking();
    write(3'd7, 16'h0000);
    for (int j = 0; j < 8; j++) begin
      sb.push_back({16'h0000, (j == 7)});
      rd_wait(3'(j));
      exp_v = sb.pop_front();
      n_total++;
      if ({OUT, OUT_VALID} !== exp_v)
        $display("FAIL valid_addr%0d: OUT=%h VALID=%b, required OUT=%h VALID=%b",
                 j, OUT, OUT_VALID, exp_v[c_W:1], exp_v[0]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    model_clear();
    test_reset();
    test_walk();
    test_hold();
    test_read_during_write();
    test_reset_mid_write();
    test_valid_tracking();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
